// File: rtl/nios_debug_scan_pkg.sv
// rtl/nios_debug_scan_pkg.sv - shared types and constants for the Nios II debug scan master
package nios_debug_scan_pkg;

  // Virtual-JTAG sequence walked for every command.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RSP
  } scan_state_t;

  // Virtual IR codes understood by the Nios II JTAG debug module.
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nios_debug_scan_if.sv
// rtl/nios_debug_scan_if.sv - command/response handshake bundle of the debug scan master
interface nios_debug_scan_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;

  // Host side: issues commands and consumes responses.
  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Scan master side.
  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/nios_debug_scan_tck_gen.sv
// rtl/nios_debug_scan_tck_gen.sv - divided tck generator with rise and period-start pulses
module nios_debug_scan_tck_gen
  import nios_debug_scan_pkg::*;
#(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic tck_rise_en,
  output logic period_start_en
);

  localparam int            CW       = cnt_width(TCK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          half_end;

  // The edge ending a half-period either raises tck (mid period) or drops it,
  // which is also the edge that starts the next period.
  assign half_end        = run && (div_cnt == DIV_LAST);
  assign tck_rise_en     = half_end && !tck;
  assign period_start_en = half_end && tck;

  // Half-period divider; parked with tck low whenever no scan is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tck     <= !tck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nios_debug_scan_master.sv
// rtl/nios_debug_scan_master.sv - virtual-JTAG scan initiator for the Nios II debug module
module nios_debug_scan_master
  import nios_debug_scan_pkg::*;
#(
  parameter int SR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 4,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  nios_debug_scan_if.slave    bus,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic                busy
);

  localparam int            BW       = cnt_width(SR_WIDTH);
  localparam int            RW       = cnt_width(RTI_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_WIDTH - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

  scan_state_t         state;
  logic [SR_WIDTH-1:0] shift;
  logic [BW-1:0]       bit_cnt;
  logic                shift_done;
  logic [RW-1:0]       rti_cnt;
  logic                run;
  logic                tck_rise_en;
  logic                period_start_en;

  // tck only runs while walking the JTAG states; IDLE and RSP keep it low.
  assign run = (state != ST_IDLE) && (state != ST_RSP);

  nios_debug_scan_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .tck             (tck),
    .tck_rise_en     (tck_rise_en),
    .period_start_en (period_start_en)
  );

  // Scan sequencer: state and strobes advance on period starts, tdo is shifted
  // in on tck rises, so everything the target sees is stable while tck is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      shift          <= '0;
      bit_cnt        <= '0;
      shift_done     <= 1'b0;
      rti_cnt        <= '0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b0;
      busy           <= 1'b0;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            ir_in         <= bus.cmd_ir;
            shift         <= bus.cmd_data;
            state         <= ST_UIR;
            vs_uir        <= 1'b1;
            busy          <= 1'b1;
            bus.cmd_ready <= 1'b0;
          end
        end
        ST_UIR: begin
          if (period_start_en) begin
            state  <= ST_CDR;
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
            tdi    <= shift[0];
          end
        end
        ST_CDR: begin
          if (period_start_en) begin
            state      <= ST_SHIFT;
            vs_cdr     <= 1'b0;
            vs_sdr     <= 1'b1;
            bit_cnt    <= '0;
            shift_done <= 1'b0;
            tdi        <= shift[0];
          end
        end
        ST_SHIFT: begin
          if (tck_rise_en) begin
            shift <= {tdo, shift[SR_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              shift_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (period_start_en) begin
            if (shift_done) begin
              state        <= ST_UDR;
              vs_sdr       <= 1'b0;
              vs_udr       <= 1'b1;
              tdi          <= 1'b0;
              bus.rsp_data <= shift;
            end else begin
              tdi <= shift[0];
            end
          end
        end
        ST_UDR: begin
          if (period_start_en) begin
            state          <= ST_RTI;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            rti_cnt        <= '0;
          end
        end
        ST_RTI: begin
          if (period_start_en) begin
            if (rti_cnt == RTI_LAST) begin
              state          <= ST_RSP;
              jtag_state_rti <= 1'b0;
              bus.rsp_valid  <= 1'b1;
            end else begin
              rti_cnt <= rti_cnt + RW'(1);
            end
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// tb/tb_nios_debug_scan_master.sv - directed self-checking bench for nios_debug_scan_master
module tb_nios_debug_scan_master;
  import nios_debug_scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default-parameter DUT
  nios_debug_scan_if #(.SR_WIDTH(38), .IR_WIDTH(2)) bus ();
  logic       tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti, busy;
  logic [1:0] ir_in;
  logic       tdo_loop, tdo_val;
  assign tdo = tdo_loop ? tdi : tdo_val;

  nios_debug_scan_master dut (
    .clk(clk), .reset(reset), .bus(bus), .tck(tck), .tdi(tdi), .tdo(tdo),
    .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
    .vs_udr(vs_udr), .jtag_state_rti(rti), .busy(busy)
  );

  // Minimal DUT: TCK_DIV=1, SR_WIDTH=2, RTI_CYCLES=1, tdo looped back
  nios_debug_scan_if #(.SR_WIDTH(2), .IR_WIDTH(2)) sbus ();
  logic       s_tck, s_tdi, s_uir, s_cdr, s_sdr, s_udr, s_rti, s_busy;
  logic [1:0] s_ir_in;

  nios_debug_scan_master #(.SR_WIDTH(2), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1)) sdut (
    .clk(clk), .reset(reset), .bus(sbus), .tck(s_tck), .tdi(s_tdi), .tdo(s_tdi),
    .ir_in(s_ir_in), .vs_uir(s_uir), .vs_cdr(s_cdr), .vs_sdr(s_sdr),
    .vs_udr(s_udr), .jtag_state_rti(s_rti), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  int lat, n_uir, n_cdr, n_sdr, n_udr, n_rti, order_err, tdi_ones;
  int stall_err, seen_rsp, accepts, rsps, ir_err, toggles;
  logic [37:0] got;
  logic [1:0]  exp_ir;
  logic        pend, prev_tck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command on the default DUT (called at a negedge while idle) and
  // follow it clock by clock until rsp_valid or the cycle budget runs out.
  task automatic run_scan(input logic [1:0] ir, input logic [37:0] data);
    int code, last, nstb;
    bus.cmd_ir    = ir;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    order_err = 0; tdi_ones = 0; last = 0;
    while (!bus.rsp_valid && lat < 1000) begin
      nstb = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(rti);
      if (nstb != 1) order_err++;
      code = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : 5;
      if (code < last) order_err++;
      last = code;
      n_uir += int'(vs_uir);
      n_cdr += int'(vs_cdr);
      n_sdr += int'(vs_sdr);
      n_udr += int'(vs_udr);
      n_rti += int'(rti);
      if (vs_sdr && tdi) tdi_ones++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = bus.rsp_data;
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b1;
    sbus.cmd_valid = 1'b0; sbus.cmd_ir = '0; sbus.cmd_data = '0; sbus.rsp_ready = 1'b1;
    tdo_loop = 1'b1; tdo_val = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_tck_busy_ir", {tck, busy, ir_in}, 0);
    check("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr, rti}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Loopback scan: data returns unchanged, strobes for their period counts
    run_scan(IR_OCIMEM, 38'h2A_5555_AAAA);
    check("loop_latency", lat, 344);
    check("loop_rsp_data", got, 38'h2A_5555_AAAA);
    check("loop_uir_clks", n_uir, 8);
    check("loop_cdr_clks", n_cdr, 8);
    check("loop_sdr_clks", n_sdr, 304);
    check("loop_udr_clks", n_udr, 8);
    check("loop_rti_clks", n_rti, 16);
    check("loop_order_onehot", order_err, 0);
    check("loop_ir_in", ir_in, IR_OCIMEM);
    check("loop_tck_rsp", tck, 0);
    @(posedge clk);
    @(negedge clk);
    check("loop_retire_ready", {bus.cmd_ready, bus.rsp_valid, busy}, 3'b100);

    // tdo tied high with zero data, response held off for 20 clks
    tdo_loop = 1'b0; tdo_val = 1'b1;
    bus.rsp_ready = 1'b0;
    run_scan(IR_TRACEMEM, 38'h0);
    check("ones_latency", lat, 344);
    check("ones_rsp_data", got, 38'h3F_FFFF_FFFF);
    check("ones_tdi_in_shift", tdi_ones, 0);
    stall_err = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== 38'h3F_FFFF_FFFF || bus.cmd_ready || tck) stall_err++;
    end
    check("stall_stable", stall_err, 0);
    bus.rsp_ready = 1'b1;
    check("stall_ready_before_edge", bus.cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("stall_retire", {bus.cmd_ready, bus.rsp_valid}, 2'b10);

    // Reset in the middle of SHIFT bit 17
    tdo_loop = 1'b1;
    bus.cmd_ir = IR_BREAK; bus.cmd_data = 38'h15_0F0F_3C3C; bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (155) @(negedge clk);
    check("abort_in_shift", vs_sdr, 1);
    reset = 1'b1;
    #1;
    check("abort_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr, rti}, 0);
    check("abort_tck_ready_busy", {tck, bus.cmd_ready, busy}, 3'b010);
    @(negedge clk);
    reset = 1'b0;
    seen_rsp = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp++;
    end
    check("abort_no_rsp", seen_rsp, 0);
    run_scan(IR_BREAK, 38'h15_0F0F_3C3C);
    check("after_abort_latency", lat, 344);
    check("after_abort_data", got, 38'h15_0F0F_3C3C);
    @(posedge clk);
    @(negedge clk);

    // Back-to-back commands with cmd_valid held through the first scan
    bus.cmd_ir = IR_BREAK; bus.cmd_data = 38'h01_2345_6789; bus.cmd_valid = 1'b1;
    accepts = 0; rsps = 0; ir_err = 0; pend = 1'b0; exp_ir = IR_BREAK;
    repeat (1000) begin
      if (pend) begin
        accepts++;
        exp_ir = (accepts == 1) ? IR_BREAK : IR_TRACECTRL;
        if (accepts == 1) bus.cmd_ir = IR_TRACECTRL;
        else bus.cmd_valid = 1'b0;
      end
      if (accepts > 0 && ir_in !== exp_ir) ir_err++;
      if (busy && bus.cmd_ready) ir_err++;
      if (bus.rsp_valid && bus.rsp_ready) rsps++;
      pend = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      @(negedge clk);
    end
    check("b2b_accepts", accepts, 2);
    check("b2b_responses", rsps, 2);
    check("b2b_ir_tracking", ir_err, 0);
    check("b2b_ir_hold", ir_in, IR_TRACECTRL);
    check("b2b_last_data", bus.rsp_data, 38'h01_2345_6789);

    // Minimal configuration: tck toggles every clk, 12-clk latency
    sbus.cmd_ir = IR_TRACEMEM; sbus.cmd_data = 2'b10; sbus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sbus.cmd_valid = 1'b0;
    lat = 0; toggles = 0; prev_tck = s_tck;
    while (!sbus.rsp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (s_tck !== prev_tck) toggles++;
      prev_tck = s_tck;
    end
    check("small_latency", lat, 12);
    check("small_toggles", toggles, 12);
    check("small_rsp_data", sbus.rsp_data, 2'b10);
    check("small_ir_in", s_ir_in, IR_TRACEMEM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
